// File: rtl/ysyx_22050133_div_pkg.sv
// Shared types and constants for the iterative divider.
package ysyx_22050133_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int unsigned WORD_W = 32;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/ysyx_22050133_div_signfix.sv
// Combinational sign handling around the unsigned divider core: operand
// magnitude/sign extraction on the way in, negation and word sign-extension on the way out.
module ysyx_22050133_div_signfix
  import ysyx_22050133_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            op_divw,
  input  logic            op_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] dvd_mag,
  output logic [XLEN-1:0] dvs_mag,
  output logic            dvd_neg,
  output logic            dvs_neg,
  input  logic            res_divw,
  input  logic [XLEN-1:0] q_mag,
  input  logic [XLEN-1:0] r_mag,
  input  logic            q_neg,
  input  logic            r_neg,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam logic [XLEN-1:0] WORD_MASK = XLEN'({WORD_W{1'b1}});

  function automatic logic [XLEN-1:0] sext_word(input logic [XLEN-1:0] v);
    return XLEN'($signed(v[WORD_W-1:0]));
  endfunction

  logic [XLEN-1:0] dvd_w, dvs_w, q_s, r_s;

  always_comb begin
    dvd_w   = op_divw ? sext_word(dividend) : dividend;
    dvs_w   = op_divw ? sext_word(divisor)  : divisor;
    dvd_neg = op_signed & dvd_w[XLEN-1];
    dvs_neg = op_signed & dvs_w[XLEN-1];
    dvd_mag = dvd_neg ? -dvd_w : dvd_w;
    dvs_mag = dvs_neg ? -dvs_w : dvs_w;
    // Word magnitudes are unsigned 32-bit values; drop the sign-extension.
    if (op_divw) begin
      dvd_mag = dvd_mag & WORD_MASK;
      dvs_mag = dvs_mag & WORD_MASK;
    end

    q_s       = q_neg ? -q_mag : q_mag;
    r_s       = r_neg ? -r_mag : r_mag;
    quotient  = res_divw ? sext_word(q_s) : q_s;
    remainder = res_divw ? sext_word(r_s) : r_s;
  end

endmodule

// File: rtl/ysyx_22050133_iter_divider.sv
// Restoring radix-2 iterative divider, one quotient bit per cycle.
// Optional macro YSYX_22050133_DIV_EARLY_OUT_EN: divide-by-zero and signed overflow skip CALC.
module ysyx_22050133_iter_divider
  import ysyx_22050133_div_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            div_valid,
  input  logic            divw,
  input  logic            div_signed,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            div_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  generate
    if (!xlen_legal(XLEN)) begin : g_bad_xlen
      $error("ysyx_22050133_iter_divider: XLEN must be 32 or 64");
    end
  endgenerate

  localparam int unsigned     CNT_W     = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] WORD_MASK = XLEN'({WORD_W{1'b1}});
  localparam logic [XLEN-1:0] WORD_MSB  = XLEN'(1) << (WORD_W - 1);
  localparam logic [XLEN-1:0] XLEN_MSB  = XLEN'(1) << (XLEN - 1);
  localparam bit              HAS_WORD  = (XLEN > WORD_W);

  div_state_e state, state_next;

  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  q_reg, rem_reg, dvs_reg, dvd_reg;
  logic             m_divw, m_qneg, m_rneg, m_dz, m_ovf;

  logic             in_divw, accept, early, load_result;
  logic [XLEN-1:0]  in_dvd_mag, in_dvs_mag;
  logic             in_dvd_neg, in_dvs_neg, in_dz, in_ovf;

  logic [XLEN:0]    rem_shift, diff;
  logic             ge;
  logic [XLEN-1:0]  q_next, rem_next;

  logic             res_divw, res_qneg, res_rneg;
  logic [XLEN-1:0]  res_q_mag, res_r_mag, fin_q, fin_r;

  assign in_divw   = HAS_WORD & divw;
  assign div_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = div_valid & div_ready & ~flush;

  ysyx_22050133_div_signfix #(
    .XLEN(XLEN)
  ) u_signfix (
    .op_divw   (in_divw),
    .op_signed (div_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .dvd_mag   (in_dvd_mag),
    .dvs_mag   (in_dvs_mag),
    .dvd_neg   (in_dvd_neg),
    .dvs_neg   (in_dvs_neg),
    .res_divw  (res_divw),
    .q_mag     (res_q_mag),
    .r_mag     (res_r_mag),
    .q_neg     (res_qneg),
    .r_neg     (res_rneg),
    .quotient  (fin_q),
    .remainder (fin_r)
  );

  assign in_dz  = (in_dvs_mag == '0);
  assign in_ovf = div_signed & in_dvd_neg & in_dvs_neg & (in_dvs_mag == XLEN'(1))
                & (in_dvd_mag == (in_divw ? WORD_MSB : XLEN_MSB));

`ifdef YSYX_22050133_DIV_EARLY_OUT_EN
  assign early = accept & (in_dz | in_ovf);
`else
  assign early = 1'b0;
`endif

  // Restoring step: the borrow bit of the trial subtraction is the inverted quotient bit.
  always_comb begin
    rem_shift = {rem_reg, q_reg[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_reg};
    ge        = ~diff[XLEN];
    rem_next  = ge ? diff[XLEN-1:0] : rem_shift[XLEN-1:0];
    q_next    = {q_reg[XLEN-2:0], ge};
  end

  always_comb begin
    res_divw  = m_divw;
    res_qneg  = m_qneg;
    res_rneg  = m_rneg;
    res_q_mag = m_divw ? (q_next & WORD_MASK) : q_next;
    res_r_mag = rem_next;
    if (m_dz) begin
      res_q_mag = '1;
      res_r_mag = dvd_reg;
      res_qneg  = 1'b0;
      res_rneg  = 1'b0;
    end else if (m_ovf) begin
      res_q_mag = dvd_reg;
      res_r_mag = '0;
      res_qneg  = 1'b0;
      res_rneg  = 1'b0;
    end
`ifdef YSYX_22050133_DIV_EARLY_OUT_EN
    // Early-out results are formed straight from the live operands at accept.
    if (state == IDLE) begin
      res_divw  = in_divw;
      res_qneg  = 1'b0;
      res_rneg  = 1'b0;
      res_q_mag = in_dz ? '1 : dividend;
      res_r_mag = in_dz ? dividend : '0;
    end
`endif
  end

  assign load_result = early | ((state == CALC) & (cnt == CNT_W'(1)) & ~flush);

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = early ? DONE : CALC;
      CALC:    if (cnt == CNT_W'(1)) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      q_reg     <= '0;
      rem_reg   <= '0;
      dvs_reg   <= '0;
      dvd_reg   <= '0;
      m_divw    <= 1'b0;
      m_qneg    <= 1'b0;
      m_rneg    <= 1'b0;
      m_dz      <= 1'b0;
      m_ovf     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else begin
      if (accept) begin
        m_divw  <= in_divw;
        m_qneg  <= in_dvd_neg ^ in_dvs_neg;
        m_rneg  <= in_dvd_neg;
        m_dz    <= in_dz;
        m_ovf   <= in_ovf;
        dvd_reg <= dividend;
        dvs_reg <= in_dvs_mag;
        rem_reg <= '0;
        // Word ops start at bit 31 so the shared MSB-first shifter needs no width mux.
        q_reg   <= in_divw ? (in_dvd_mag << (XLEN - WORD_W)) : in_dvd_mag;
        cnt     <= CNT_W'(in_divw ? WORD_W : XLEN);
      end else if (state == CALC) begin
        cnt     <= cnt - CNT_W'(1);
        q_reg   <= q_next;
        rem_reg <= rem_next;
      end
      if (load_result) begin
        quotient  <= fin_q;
        remainder <= fin_r;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050133_iter_divider.sv
// Directed self-checking bench for ysyx_22050133_iter_divider at XLEN=64.
module tb_ysyx_22050133_iter_divider;

  logic        clk = 1'b0;
  logic        rst, flush, div_valid, divw, div_signed, out_ready;
  logic [63:0] dividend, divisor, quotient, remainder;
  logic        div_ready, out_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic        w;
    logic        s;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] q;
    logic [63:0] r;
    int          lat;
  } vec_t;

  always #5 clk = ~clk;

  ysyx_22050133_iter_divider #(.XLEN(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .div_valid  (div_valid),
    .divw       (divw),
    .div_signed (div_signed),
    .dividend   (dividend),
    .divisor    (divisor),
    .div_ready  (div_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // lat = clock edges after the accepting edge until out_valid is seen;
  // a consumer first samples it at edge lat+1.
  function automatic int sp_lat(input int n);
`ifdef YSYX_22050133_DIV_EARLY_OUT_EN
    return 0;
`else
    return n;
`endif
  endfunction

  task automatic start_op(input logic w, input logic s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    divw = w; div_signed = s; dividend = a; divisor = b; div_valid = 1'b1;
    @(posedge clk); #1;
    div_valid = 1'b0;
    dividend = 64'hDEAD_BEEF_0BAD_F00D; divisor = 64'h3; divw = ~w; div_signed = ~s;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic pop();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  task automatic run_table(input vec_t v[$]);
    int lat;
    foreach (v[i]) begin
      start_op(v[i].w, v[i].s, v[i].a, v[i].b);
      wait_valid(lat);
      n_cmp++;
      if (lat !== v[i].lat) begin
        n_bad++; $display("FAIL %s latency got %0d want %0d", v[i].name, lat, v[i].lat);
      end
      n_cmp++;
      if (quotient !== v[i].q) begin
        n_bad++; $display("FAIL %s quotient got %h want %h", v[i].name, quotient, v[i].q);
      end
      n_cmp++;
      if (remainder !== v[i].r) begin
        n_bad++; $display("FAIL %s remainder got %h want %h", v[i].name, remainder, v[i].r);
      end
      pop();
    end
  endtask

  task automatic count_stray_valid(input string name, input int cycles);
    int seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_bad++; $display("FAIL %s out_valid seen %0d cycles want 0", name, seen);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; div_valid = 1'b0; divw = 1'b0; div_signed = 1'b0;
    out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (quotient !== 64'h0) begin n_bad++; $display("FAIL reset_quot got %h want 0", quotient); end
    n_cmp++; if (remainder !== 64'h0) begin n_bad++; $display("FAIL reset_rem got %h want 0", remainder); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", div_ready); end
  endtask

  task automatic test_basic();
    vec_t v[$];
    v.push_back('{"u100_7",  1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 64});
    v.push_back('{"u1000_10",1'b0, 1'b0, 64'd1000, 64'd10, 64'd100, 64'd0, 64});
    v.push_back('{"s_m7_2",  1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64});
    v.push_back('{"s_7_m2",  1'b0, 1'b1, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 64});
    v.push_back('{"s_m7_m2", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFFE,
                  64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64});
    v.push_back('{"u_big",   1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000,
                  64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64});
    run_table(v);
  endtask

  task automatic test_special();
    vec_t v[$];
    v.push_back('{"u5_div0",  1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, sp_lat(64)});
    v.push_back('{"s_m5_div0",1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, sp_lat(64)});
    v.push_back('{"s_ovf",    1'b0, 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 64'd0, sp_lat(64)});
    v.push_back('{"u_min_m1", 1'b0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'd0, 64'h8000_0000_0000_0000, 64});
    run_table(v);
  endtask

  task automatic test_divw();
    vec_t v[$];
    v.push_back('{"w_s_ovf",  1'b1, 1'b1, 64'h1234_5678_8000_0000, 64'hABCD_0000_FFFF_FFFF,
                  64'hFFFF_FFFF_8000_0000, 64'd0, sp_lat(32)});
    v.push_back('{"w_u_ff_1", 1'b1, 1'b0, 64'h5555_5555_FFFF_FFFF, 64'h7777_7777_0000_0001,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 32});
    v.push_back('{"w_s_m7_2", 1'b1, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'h9999_0000_0000_0002,
                  64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 32});
    v.push_back('{"w_u_m7_2", 1'b1, 1'b0, 64'h0000_0000_FFFF_FFF9, 64'd2,
                  64'h0000_0000_7FFF_FFFC, 64'd1, 32});
    v.push_back('{"w_u_div0", 1'b1, 1'b0, 64'hAAAA_AAAA_0000_0005, 64'h1111_1111_0000_0000,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'd5, sp_lat(32)});
    v.push_back('{"w_u_min",  1'b1, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
                  64'd0, 64'hFFFF_FFFF_8000_0000, 32});
    run_table(v);
  endtask

  task automatic test_back_to_back();
    int lat;
    start_op(1'b0, 1'b0, 64'd1000, 64'd10);
    wait_valid(lat);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL hold%0d_valid got %b want 1", k, out_valid); end
      n_cmp++; if (quotient !== 64'd100) begin n_bad++; $display("FAIL hold%0d_quot got %h want 64", k, quotient); end
      n_cmp++; if (remainder !== 64'd0) begin n_bad++; $display("FAIL hold%0d_rem got %h want 0", k, remainder); end
      n_cmp++; if (div_ready !== 1'b0) begin n_bad++; $display("FAIL hold%0d_ready got %b want 0", k, div_ready); end
    end
    @(negedge clk);
    out_ready = 1'b1; div_valid = 1'b1; divw = 1'b0; div_signed = 1'b0;
    dividend = 64'd81; divisor = 64'd9;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drop_valid got %b want 0", out_valid); end
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_no_accept got %b want 1", div_ready); end
    @(posedge clk); #1;
    div_valid = 1'b0;
    n_cmp++; if (div_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept got %b want 0", div_ready); end
    wait_valid(lat);
    n_cmp++; if (lat !== 64) begin n_bad++; $display("FAIL b2b_latency got %0d want 64", lat); end
    n_cmp++; if (quotient !== 64'd9) begin n_bad++; $display("FAIL b2b_quot got %h want 9", quotient); end
    n_cmp++; if (remainder !== 64'd0) begin n_bad++; $display("FAIL b2b_rem got %h want 0", remainder); end
    pop();
  endtask

  task automatic test_flush();
    int lat;
    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL flush_calc_ready got %b want 1", div_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_calc_valid got %b want 0", out_valid); end
    count_stray_valid("flush_calc_stray", 80);

    @(negedge clk);
    flush = 1'b1; div_valid = 1'b1; divw = 1'b0; div_signed = 1'b0;
    dividend = 64'd100; divisor = 64'd7;
    @(posedge clk); #1;
    flush = 1'b0; div_valid = 1'b0;
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL flush_vs_accept got %b want 1", div_ready); end
    count_stray_valid("flush_idle_stray", 70);

    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done_valid got %b want 0", out_valid); end
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL flush_done_ready got %b want 1", div_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    start_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
    repeat (20) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (quotient !== 64'h0) begin n_bad++; $display("FAIL rstmid_quot got %h want 0", quotient); end
    n_cmp++; if (remainder !== 64'h0) begin n_bad++; $display("FAIL rstmid_rem got %h want 0", remainder); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_valid got %b want 0", out_valid); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (div_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_ready got %b want 1", div_ready); end
    count_stray_valid("rstmid_stray", 70);

    start_op(1'b0, 1'b0, 64'd100, 64'd7);
    wait_valid(lat);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstdone_valid got %b want 0", out_valid); end
    count_stray_valid("rstdone_stray", 10);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_special();
    test_divw();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ysyx_22050133_iter_divider.md
YSYX_22050133_ITER_DIVIDER -- requirements
Module: ysyx_22050133_iter_divider

Interface
REQ-001 Parameter XLEN, default 64, datapath width; legal values 32 and 64.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 flush  input  1  abandons any in-flight division.
REQ-005 div_valid  input  1  request valid.
REQ-006 divw  input  1  32-bit word op (RV64 *W); ignored when XLEN=32.
REQ-007 div_signed  input  1  1 signed, 0 unsigned.
REQ-008 dividend, divisor  input  XLEN each  operands, sampled on accept.
REQ-009 div_ready  output  1  high only in IDLE.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 quotient, remainder  output  XLEN each  results.

Function
REQ-013 FSM states IDLE, CALC, DONE; accept = div_valid & div_ready, IDLE->CALC on accept.
REQ-014 Operands and mode are latched on accept; later input changes have no effect.
REQ-015 Restoring radix-2, one quotient bit per cycle; CALC lasts N cycles, N = 32 if divw else XLEN.
REQ-016 Accept at edge T: out_valid high from edge T+N+1.
REQ-017 DONE holds out_valid, quotient and remainder stable until out_ready; DONE->IDLE on the edge where out_ready=1.
REQ-018 No new request is accepted in the DONE->IDLE cycle; div_ready rises the cycle after.
REQ-019 Signed mode: divide magnitudes; negate quotient if operand signs differ; remainder takes the dividend's sign.
REQ-020 divw: use operand bits [31:0] only; quotient and remainder sign-extended from bit 31, both signed and unsigned.
REQ-021 Divisor zero: quotient all ones (word-width, then sign-extended for divw), remainder = dividend (word-width for divw).
REQ-022 Signed overflow, most-negative / -1 at the operating width: quotient = dividend, remainder = 0.
REQ-023 flush high in any state: next state IDLE and out_valid low next cycle; flush takes priority over accept and out_ready.
REQ-024 quotient and remainder outputs are undefined-but-stable outside DONE; checks only while out_valid=1.

Reset
REQ-025 rst=0 at a clk edge: state IDLE, out_valid 0, quotient 0, remainder 0, counter 0; div_ready 1 after release.
REQ-026 Reset mid-CALC or in DONE discards the operation; no out_valid pulse follows.

Configuration
REQ-027 Macro YSYX_22050133_DIV_EARLY_OUT_EN defined: divide-by-zero and signed overflow go IDLE->DONE directly, out_valid at T+1.
REQ-028 Macro undefined: special cases run the full N-cycle CALC, out_valid at T+N+1; result values are identical in both builds.

Structure
REQ-029 Package ysyx_22050133_div_pkg holds the state enum, the XLEN legality check and the word width constant 32.
REQ-030 Sub-module ysyx_22050133_div_signfix (combinational) does operand magnitude/sign extraction, result negation and divw sign-extension.
REQ-031 The top level holds the FSM, counter, partial-remainder register and shift register.

Verification
REQ-032 XLEN=64, unsigned 100/7 -> quotient 14, remainder 2, out_valid at T+65.
REQ-033 Signed -7/2 -> quotient 0xFFFF_FFFF_FFFF_FFFD, remainder 0xFFFF_FFFF_FFFF_FFFF.
REQ-034 5/0 unsigned -> quotient 0xFFFF_FFFF_FFFF_FFFF, remainder 5; out_valid at T+1 with macro, T+65 without.
REQ-035 Signed 0x8000_0000_0000_0000 / -1 -> quotient 0x8000_0000_0000_0000, remainder 0.
REQ-036 divw signed 0x8000_0000 / 0xFFFF_FFFF -> quotient 0xFFFF_FFFF_8000_0000, remainder 0, out_valid at T+33.
REQ-037 divw unsigned 0xFFFF_FFFF/1 -> quotient 0xFFFF_FFFF_FFFF_FFFF.
REQ-038 flush at CALC cycle 10 -> div_ready next cycle, no out_valid.
REQ-039 out_ready held low 3 cycles -> results stable in all 3 cycles; rst=0 mid-CALC -> outputs 0.
